// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DEF_AW       = 6;
    localparam int DEF_DW       = 32;
    localparam int DEF_MAX_LOCK = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        COOL   = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_CPU  = 1'b0,
        PORT_HOST = 1'b1
    } port_id_e;

    // On a tie the port that was not served last gets the slot.
    function automatic port_id_e tie_winner(input port_id_e last_served);
        return (last_served == PORT_HOST) ? PORT_CPU : PORT_HOST;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / host loader) arbiter in front of a single-port synchronous
// data RAM. Round-robin on ties, optional host locked bursts bounded by
// MAX_LOCK beats, and a one-cycle cool-down that guarantees the CPU a slot
// after every burst.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          host_req,
    input  logic          host_we,
    input  logic          host_lock,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] rd_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Counter must reach MAX_LOCK itself without wrapping.
    localparam int            CW      = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

    arb_state_e    state_q;
    logic [CW-1:0] cnt_q;
    port_id_e      last_q;
    logic          cpu_rvalid_q;
    logic          host_rvalid_q;

    logic          cpu_gnt_s;
    logic          host_gnt_s;
    logic          cpu_acc_s;
    logic          host_acc_s;
    logic [CW-1:0] cnt_inc_s;

    // Grant decision: combinational from requests and current state, forced low in reset.
    always_comb begin
        cpu_gnt_s  = 1'b0;
        host_gnt_s = 1'b0;
        if (reset) begin
            cpu_gnt_s  = 1'b0;
            host_gnt_s = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req && host_req) begin
                        cpu_gnt_s  = (tie_winner(last_q) == PORT_CPU);
                        host_gnt_s = (tie_winner(last_q) == PORT_HOST);
                    end else begin
                        cpu_gnt_s  = cpu_req;
                        host_gnt_s = host_req;
                    end
                end
                LOCKED: begin
                    host_gnt_s = host_req;
                end
                COOL: begin
                    cpu_gnt_s = cpu_req;
                end
                default: begin
                    cpu_gnt_s  = 1'b0;
                    host_gnt_s = 1'b0;
                end
            endcase
        end
    end

    assign cpu_acc_s  = cpu_req & cpu_gnt_s;
    assign host_acc_s = host_req & host_gnt_s;
    assign cnt_inc_s  = cnt_q + CNT_ONE;

    // RAM request mux: the granted port drives the RAM, everything is zero otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        if (cpu_gnt_s) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (host_gnt_s) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = {AW{1'b0}};
            mem_wdata = {DW{1'b0}};
        end
    end

    // Arbitration FSM, burst beat counter, round-robin pointer and read-return flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= {CW{1'b0}};
            last_q        <= PORT_HOST;
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q  <= cpu_acc_s & ~cpu_we;
            host_rvalid_q <= host_acc_s & ~host_we;
            case (state_q)
                IDLE: begin
                    if (cpu_acc_s) begin
                        last_q <= PORT_CPU;
                    end
                    if (host_acc_s) begin
                        last_q <= PORT_HOST;
                        if (host_lock) begin
                            cnt_q   <= CNT_ONE;
                            state_q <= (CNT_ONE == CNT_MAX) ? COOL : LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (host_acc_s) begin
                        cnt_q  <= cnt_inc_s;
                        last_q <= PORT_HOST;
                    end
                    // The closing beat (lock dropped or limit reached) still completes.
                    if (!host_lock || (host_acc_s && (cnt_inc_s == CNT_MAX))) begin
                        state_q <= COOL;
                    end
                end
                COOL: begin
                    state_q <= IDLE;
                    cnt_q   <= {CW{1'b0}};
                    last_q  <= PORT_HOST;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= {CW{1'b0}};
                    last_q  <= PORT_HOST;
                end
            endcase
        end
    end

    assign cpu_gnt     = cpu_gnt_s;
    assign host_gnt    = host_gnt_s;
    assign mem_en      = cpu_gnt_s | host_gnt_s;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign host_rvalid = host_rvalid_q;
    assign rd_data     = (cpu_rvalid_q | host_rvalid_q) ? mem_rdata : {DW{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural reference model.
module tb_dmem_arbiter;

    localparam int AW   = 6;
    localparam int DW   = 32;
    localparam int MAXL = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
    logic [DW-1:0] rd_data;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAXL)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Environment RAM: synchronous single-port, read data one cycle after enable.
    logic [DW-1:0] ram [0:63];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference model state (spec-level: who owns the memory, beats used, fairness bit).
    logic [DW-1:0] ref_mem [0:63];
    int  mode = 0;          // 0 = open arbitration, 1 = host owns memory, 2 = cool-down
    int  beats = 0;
    bit  last_host = 1'b1;
    bit  e_cg = 1'b0, e_hg = 1'b0;
    int  cyc = 0;

    typedef struct {bit host; logic [DW-1:0] data; int due;} rd_t;
    rd_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int host_run = 0;
    int max_run = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Who should hold the memory this cycle, from the current inputs.
    function automatic void predict();
        e_cg = 1'b0;
        e_hg = 1'b0;
        if (!reset) begin
            if (mode == 1) e_hg = host_req;
            else if (mode == 2) e_cg = cpu_req;
            else if (cpu_req && host_req) begin
                if (last_host) e_cg = 1'b1; else e_hg = 1'b1;
            end else begin
                e_cg = cpu_req;
                e_hg = host_req;
            end
        end
    endfunction

    // Apply the transfer the model expects to be accepted on this edge.
    function automatic void model_edge();
        bit ca, ha;
        rd_t r;
        if (reset) return;
        ca = cpu_req && e_cg;
        ha = host_req && e_hg;
        if (ca) begin
            if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            else begin r.host = 1'b0; r.data = ref_mem[cpu_addr]; r.due = cyc; exp_q.push_back(r); end
        end
        if (ha) begin
            if (host_we) ref_mem[host_addr] = host_wdata;
            else begin r.host = 1'b1; r.data = ref_mem[host_addr]; r.due = cyc; exp_q.push_back(r); end
        end
        if (mode == 0) begin
            if (ca) last_host = 1'b0;
            if (ha) begin
                last_host = 1'b1;
                if (host_lock) begin
                    beats = 1;
                    mode = (beats == MAXL) ? 2 : 1;
                end
            end
        end else if (mode == 1) begin
            if (ha) beats++;
            if (!host_lock || (ha && beats == MAXL)) mode = 2;
        end else begin
            mode = 0;
            beats = 0;
            last_host = 1'b1;
        end
    endfunction

    task automatic step(input bit rst, input bit cr, input bit cw, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input bit hr, input bit hw, input bit hl,
                        input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        reset = rst;
        if (rst) begin
            exp_q.delete();
            mode = 0;
            beats = 0;
            last_host = 1'b1;
        end
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_we = hw; host_lock = hl; host_addr = ha; host_wdata = hd;
        predict();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    // Monitor: grant/bus checks each cycle and scoreboard pops on read returns.
    always @(negedge clk) begin
        rd_t r;
        logic [39:0] exp_bus;
        chk("grants", {62'd0, cpu_gnt, host_gnt}, {62'd0, e_cg, e_hg});
        if (e_cg)      exp_bus = {1'b1, cpu_we, cpu_addr, cpu_wdata};
        else if (e_hg) exp_bus = {1'b1, host_we, host_addr, host_wdata};
        else           exp_bus = '0;
        chk("mem_bus", {24'd0, mem_en, mem_we, mem_addr, mem_wdata}, {24'd0, exp_bus});
        if (cpu_rvalid || host_rvalid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rvalid", {62'd0, cpu_rvalid, host_rvalid}, 64'd0);
            end else begin
                r = exp_q.pop_front();
                chk("rvalid_owner", {62'd0, cpu_rvalid, host_rvalid}, {62'd0, !r.host, r.host});
                chk("rd_data", {32'd0, rd_data}, {32'd0, r.data});
                chk("rvalid_time", 64'(cyc), 64'(r.due));
            end
        end else begin
            chk("rd_data_idle", {32'd0, rd_data}, 64'd0);
            if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                r = exp_q.pop_front();
                chk("missing_rvalid", {62'd0, cpu_rvalid, host_rvalid}, {62'd0, !r.host, r.host});
            end
        end
        if (host_gnt && host_req) host_run++;
        else begin
            if (host_run > max_run) max_run = host_run;
            host_run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] burst_d [0:3];
        int idx;
        burst_d[0] = 32'd5; burst_d[1] = 32'd2; burst_d[2] = 32'd9; burst_d[3] = 32'd1;
        for (int i = 0; i < 64; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[3] = 32'h1;
        ref_mem[3] = 32'h1;

        // Reset held: everything quiet.
        for (int k = 0; k < 3; k++) step(1'b1, 1, 0, 6'd1, '0, 1, 0, 1, 6'd2, '0);
        @(negedge clk);
        chk("reset_outs", {26'd0, cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_en, mem_we,
                           mem_addr, rd_data}, 64'd0);

        // Lone CPU read of word 3.
        step(1'b0, 1, 0, 6'd3, '0, 0, 0, 0, '0, '0);
        @(negedge clk);
        chk("cpu_lone_gnt", {63'd0, cpu_gnt}, 64'd1);
        idle(1);
        @(negedge clk);
        chk("cpu_lone_data", {31'd0, cpu_rvalid, rd_data}, {31'd0, 1'b1, 32'h1});
        idle(1);

        // Alternation after reset with both requesting.
        step(1'b1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1, 0, 6'(i), '0, 1, 0, 0, 6'(i + 8), '0);
            @(negedge clk);
            chk("alternate", {62'd0, cpu_gnt, host_gnt}, (i % 2 == 0) ? 64'd2 : 64'd1);
        end
        idle(2);

        // Locked host write burst of 4 with the CPU contending.
        idx = 0;
        for (int t = 0; t < 12 && idx < 4; t++) begin
            step(1'b0, 1, 0, 6'(t + 20), '0, 1, 1, 1, 6'(idx), burst_d[idx]);
            if (e_hg) idx++;
        end
        chk("burst_beats_issued", 64'(idx), 64'd4);
        step(1'b0, 1, 0, 6'd30, '0, 0, 0, 0, '0, '0);
        @(negedge clk);
        chk("lock_drop_cpu_blocked", {63'd0, cpu_gnt}, 64'd0);
        step(1'b0, 1, 0, 6'd31, '0, 0, 0, 0, '0, '0);
        @(negedge clk);
        chk("cool_cpu_gnt", {63'd0, cpu_gnt}, 64'd1);
        idle(2);
        for (int i = 0; i < 4; i++) chk("burst_ram", {32'd0, ram[i]}, {32'd0, burst_d[i]});

        // Host hogs lock: capped at MAX_LOCK beats.
        @(negedge clk);
        host_run = 0;
        max_run = 0;
        for (int t = 0; t < 20; t++)
            step(1'b0, 1, 0, 6'($urandom_range(0, 63)), '0, 1, 0, 1, 6'($urandom_range(0, 63)), '0);
        idle(4);
        @(negedge clk);
        chk("lock_cap_beats", 64'(max_run), 64'(MAXL));

        // Reset during a locked burst with a host read just accepted.
        step(1'b1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        for (int t = 0; t < 6 && mode != 1; t++)
            step(1'b0, 1, 0, 6'd7, '0, 1, 0, 1, 6'd9, '0);
        chk("entered_lock", 64'(mode), 64'd1);
        step(1'b0, 1, 0, 6'd7, '0, 1, 0, 1, 6'd10, '0);
        step(1'b1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        @(negedge clk);
        chk("reset_mid_burst", {26'd0, cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_en, mem_we,
                                mem_addr, rd_data}, 64'd0);
        step(1'b1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        step(1'b0, 1, 0, 6'd11, '0, 1, 0, 0, 6'd12, '0);
        @(negedge clk);
        chk("post_reset_tie", {62'd0, cpu_gnt, host_gnt}, 64'd2);
        idle(2);

        // Randomized traffic with occasional resets.
        for (int t = 0; t < 1500; t++) begin
            step(($urandom_range(0, 199) == 0),
                 $urandom_range(0, 1), $urandom_range(0, 1), 6'($urandom_range(0, 63)), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                 6'($urandom_range(0, 63)), $urandom);
        end
        idle(4);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
